// File: rtl/vh_result_pkg.sv
// vloghammer result bus layout: field widths, offsets and signedness.
// Shared by the unpacker and its field extractor.
package vh_result_pkg;

  localparam int VH_NUM_FIELDS = 18;
  localparam int VH_WORD_W     = 90;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } vh_state_e;

  // Each 30-bit group is {u4,u5,u6,s4,s5,s6}, y0 at the top.
  function automatic int vh_field_w(input int idx);
    int w;
    unique case (idx % 3)
      0:       w = 4;
      1:       w = 5;
      default: w = 6;
    endcase
    return w;
  endfunction

  function automatic int vh_field_lsb(input int idx);
    int base;
    unique case (idx % 6)
      0:       base = 86;
      1:       base = 81;
      2:       base = 75;
      3:       base = 71;
      4:       base = 66;
      default: base = 60;
    endcase
    return base - 30 * (idx / 6);
  endfunction

  function automatic bit vh_field_signed(input int idx);
    return (idx % 6) >= 3;
  endfunction

endpackage

// File: rtl/vh_field_extract.sv
// Selects one field of a packed result word and sign/zero-extends it.
// Pure combinational; every case arm folds to a fixed slice.
module vh_field_extract
  import vh_result_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [VH_WORD_W-1:0] i_word,
  input  logic [4:0]           i_idx,
  output logic [OUT_W-1:0]     o_data
);

  function automatic logic [OUT_W-1:0] ext(
    input logic [VH_WORD_W-1:0] w,
    input int                   idx
  );
    logic [VH_WORD_W-1:0] sh;
    logic [OUT_W-1:0]     v;
    int                   wd;
    wd = vh_field_w(idx);
    sh = w >> vh_field_lsb(idx);
    v  = '0;
    for (int b = 0; b < OUT_W; b++) begin
      if (b < wd)
        v[b] = sh[b];
      else if (vh_field_signed(idx))
        v[b] = sh[wd-1];
    end
    return v;
  endfunction

  always_comb begin
    o_data = '0;
    unique case (i_idx)
      5'd0:    o_data = ext(i_word, 0);
      5'd1:    o_data = ext(i_word, 1);
      5'd2:    o_data = ext(i_word, 2);
      5'd3:    o_data = ext(i_word, 3);
      5'd4:    o_data = ext(i_word, 4);
      5'd5:    o_data = ext(i_word, 5);
      5'd6:    o_data = ext(i_word, 6);
      5'd7:    o_data = ext(i_word, 7);
      5'd8:    o_data = ext(i_word, 8);
      5'd9:    o_data = ext(i_word, 9);
      5'd10:   o_data = ext(i_word, 10);
      5'd11:   o_data = ext(i_word, 11);
      5'd12:   o_data = ext(i_word, 12);
      5'd13:   o_data = ext(i_word, 13);
      5'd14:   o_data = ext(i_word, 14);
      5'd15:   o_data = ext(i_word, 15);
      5'd16:   o_data = ext(i_word, 16);
      5'd17:   o_data = ext(i_word, 17);
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/vh_result_unpacker.sv
// Serialises a packed 18-field result word, one extended field per
// output handshake, and counts completed words.
module vh_result_unpacker
  import vh_result_pkg::*;
#(
  parameter int NUM_FIELDS = 18,
  parameter int OUT_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VH_WORD_W-1:0] in_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_idx,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_last,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_FIELDS - 1);

  vh_state_e              r_state;
  vh_state_e              w_state_nxt;
  logic [VH_WORD_W-1:0]   r_word;
  logic [VH_WORD_W-1:0]   w_word_nxt;
  logic [4:0]             r_idx;
  logic [4:0]             w_idx_nxt;
  logic [OUT_W-1:0]       r_data;
  logic [OUT_W-1:0]       w_ext;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_done;

  // Data is pre-computed from next-state values so it lands with idx.
  vh_field_extract #(
    .OUT_W (OUT_W)
  ) u_extract (
    .i_word (w_word_nxt),
    .i_idx  (w_idx_nxt),
    .o_data (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_idx_nxt   = r_idx;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_word_nxt  = in_word;
          w_idx_nxt   = '0;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (r_idx == LAST_IDX) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_ext;
      r_cnt   <= r_cnt + CNT_W'(w_done);
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_EMIT);
  assign out_idx   = r_idx;
  assign out_data  = r_data;
  assign out_last  = out_valid && (r_idx == LAST_IDX);
  assign word_cnt  = r_cnt;

endmodule
